reg_write_port_arbiter: RTL and testbench
=========================================

Name: reg_write_port_arbiter

Overview:
- Shares the single register-file write port between the write-back stage and a long-latency auxiliary unit (multiply/divide).
- Write-back has priority. Auxiliary results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation counter guarantees auxiliary forward progress.
- Exports a pending-register bitmap so decode can interlock on registers whose auxiliary writes are still in flight.

Parameters:
DEPTH, 4, auxiliary result FIFO entries (power of two, ≥2)
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be denied before write-back is stalled
REG_COUNT, 32, architectural registers (id width = log2(REG_COUNT))

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset)
wbWriteEnabled  input  1  write-back requests a register write this cycle
wbWriteId  input  5  write-back destination register
wbDataWrite  input  32  write-back data
wbStall  output  1  write-back must hold its instruction this cycle (port given to auxiliary)
auxValid  input  1  auxiliary unit offers a result
auxReady  output  1  FIFO can accept a result
auxWriteId  input  5  auxiliary destination register
auxDataWrite  input  32  auxiliary data
regWriteEnabled  output  1  register-file write enable
regWriteId  output  5  register-file write address
regDataWrite  output  32  register-file write data
pendingMask  output  REG_COUNT  bit i = 1 if any buffered auxiliary entry targets register i
fifoCount  output  log2(DEPTH)+1  occupied entries (debug/verification)

Behaviour:
- Reset (reset==0 at posedge): FIFO flushed, head/tail/count = 0, starveCount = 0.
  - Outputs while reset is low: regWriteEnabled=0, wbStall=0, auxReady=0, pendingMask=0, fifoCount=0.
  - Reset mid-drain discards all buffered entries; nothing is written.
- auxReady = reset && (count < DEPTH), computed from registered count only.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- Push: auxValid && auxReady at posedge.
  - auxWriteId==0: handshake completes, no entry is stored.
  - Otherwise the entry is written at the tail.
  - An entry accepted at cycle N can be granted at N+1 at the earliest. There is no bypass.
- Grant (combinational, each cycle): grantAux = (count>0) && (!wbWriteEnabled || starveCount==STARVE_LIMIT).
  - grantAux: port driven from FIFO head; pop at posedge; wbStall = wbWriteEnabled.
  - otherwise: port driven from write-back inputs; wbStall = 0.
- regWriteEnabled is forced to 0 when the selected id is 0.
- Write-back data under wbStall must be held stable by upstream and is re-presented next cycle.
- starveCount (saturating at STARVE_LIMIT):
  - cleared when count==0 or grantAux;
  - else incremented when count>0 && wbWriteEnabled.
- Simultaneous push and pop: count unchanged; head and tail both advance. Pointers wrap modulo DEPTH.
- pendingMask: OR over valid entries of onehot(id). Updates the cycle after push/pop.
  - An entry being popped still shows its bit during the grant cycle.
- Ordering: writes occur in grant order. Decode must not issue a write-back to a register whose pendingMask bit is set.
  - Simulation-only assertion: wbWriteEnabled && grant to write-back && pendingMask[wbWriteId] is an error.

Test Plan:
- Reset: hold reset=0 3 cycles with auxValid=1 → auxReady=0, fifoCount=0, regWriteEnabled=0. Release → auxReady=1 next cycle.
- Idle drain: wb idle, push (id 5, 0xDEAD) at cycle N → cycle N+1: regWriteEnabled=1, id 5, data 0xDEAD, pendingMask=0x20 until the pop completes, then 0.
- Priority and starvation: push id 7, hold wbWriteEnabled=1 (id 3) continuously.
  - 8 cycles write id 3.
  - Cycle 9: wbStall=1, write id 7.
  - Cycle 10: write-back resumes, starveCount=0.
- Full FIFO: wb busy, push 4 entries → auxReady=0, fifoCount=4. A 5th auxValid is held off. Drained entries come out in FIFO order with wrap-around over 3 fill/drain rounds.
- Register 0: aux push id 0 → accepted, fifoCount unchanged. wbWriteEnabled with id 0 → regWriteEnabled=0.
- Mid-drain reset: 3 entries buffered, reset=0 one cycle → fifoCount=0, pendingMask=0, no writes issued after release.

Source files
------------

// File: rtl/reg_write_port_arbiter.sv
// Shares the register-file write port between write-back (priority) and a buffered aux FIFO; grant is same-cycle, aux entries drain >=1 cycle after push.
// Backpressure: auxReady drops when the FIFO is full; wbStall holds write-back when a starving FIFO takes the port.
module reg_write_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int REG_COUNT    = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wbWriteEnabled,
    input  logic [$clog2(REG_COUNT)-1:0] wbWriteId,
    input  logic [31:0]                  wbDataWrite,
    output logic                         wbStall,
    input  logic                         auxValid,
    output logic                         auxReady,
    input  logic [$clog2(REG_COUNT)-1:0] auxWriteId,
    input  logic [31:0]                  auxDataWrite,
    output logic                         regWriteEnabled,
    output logic [$clog2(REG_COUNT)-1:0] regWriteId,
    output logic [31:0]                  regDataWrite,
    output logic [REG_COUNT-1:0]         pendingMask,
    output logic [$clog2(DEPTH):0]       fifoCount
);

    localparam int IW = $clog2(REG_COUNT);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [IW-1:0]    id_mem_q  [DEPTH];
    logic [IW-1:0]    id_mem_d  [DEPTH];
    logic [31:0]      dat_mem_q [DEPTH];
    logic [31:0]      dat_mem_d [DEPTH];

    logic                 fifo_empty;
    logic                 grant_aux;
    logic                 push_acc;
    logic                 push_store;
    logic                 sel_en;
    logic [IW-1:0]        sel_id;
    logic [31:0]          sel_dat;
    logic [REG_COUNT-1:0] pend;

    // Arbitration looks only at registered FIFO state, so a fresh push never bypasses.
    always_comb begin
        fifo_empty = (count_q == '0);
        grant_aux  = reset && !fifo_empty && (!wbWriteEnabled || (starve_q == LIMIT_C));
        auxReady   = reset && (count_q < DEPTH_C);
        push_acc   = auxValid && auxReady;
        push_store = push_acc && (auxWriteId != '0);
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        vld_d     = vld_q;
        id_mem_d  = id_mem_q;
        dat_mem_d = dat_mem_q;

        if (grant_aux) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        if (push_store) begin
            vld_d[tail_q]     = 1'b1;
            id_mem_d[tail_q]  = auxWriteId;
            dat_mem_d[tail_q] = auxDataWrite;
            tail_d            = tail_q + PW'(1);
        end

        case ({push_store, grant_aux})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || grant_aux) begin
            starve_d = '0;
        end else if (wbWriteEnabled && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend[id_mem_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        if (grant_aux) begin
            sel_en  = 1'b1;
            sel_id  = id_mem_q[head_q];
            sel_dat = dat_mem_q[head_q];
        end else begin
            sel_en  = wbWriteEnabled;
            sel_id  = wbWriteId;
            sel_dat = wbDataWrite;
        end
        // Register 0 is hardwired; never pulse the write enable for it.
        regWriteEnabled = reset && sel_en && (sel_id != '0);
        regWriteId      = sel_id;
        regDataWrite    = sel_dat;
        wbStall         = grant_aux && wbWriteEnabled;
        pendingMask     = reset ? pend : '0;
        fifoCount       = reset ? count_q : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            vld_q    <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage needs no reset: vld_q qualifies every slot.
    always_ff @(posedge clock) begin
        id_mem_q  <= id_mem_d;
        dat_mem_q <= dat_mem_d;
    end

    wb_no_pending_hazard: assert property (@(posedge clock) disable iff (!reset)
        !(wbWriteEnabled && !grant_aux && pendingMask[wbWriteId]));

endmodule

// File: tb/tb_reg_write_port_arbiter.sv
// Bench for reg_write_port_arbiter: directed table, corner sequences, random traffic against a queue model.
module tb_reg_write_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        wbWriteEnabled;
    logic [4:0]  wbWriteId;
    logic [31:0] wbDataWrite;
    logic        wbStall;
    logic        auxValid;
    logic        auxReady;
    logic [4:0]  auxWriteId;
    logic [31:0] auxDataWrite;
    logic        regWriteEnabled;
    logic [4:0]  regWriteId;
    logic [31:0] regDataWrite;
    logic [31:0] pendingMask;
    logic [2:0]  fifoCount;

    always #5 clock = ~clock;

    reg_write_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .REG_COUNT(32)) dut (
        .clock(clock), .reset(reset),
        .wbWriteEnabled(wbWriteEnabled), .wbWriteId(wbWriteId), .wbDataWrite(wbDataWrite),
        .wbStall(wbStall),
        .auxValid(auxValid), .auxReady(auxReady), .auxWriteId(auxWriteId), .auxDataWrite(auxDataWrite),
        .regWriteEnabled(regWriteEnabled), .regWriteId(regWriteId), .regDataWrite(regDataWrite),
        .pendingMask(pendingMask), .fifoCount(fifoCount)
    );

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] dat;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        wbe;
        logic [4:0]  wbid;
        logic [31:0] wbd;
        logic        av;
        logic [4:0]  aid;
        logic [31:0] ad;
        logic        e_we;
        logic        e_stall;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic [31:0] e_pend;
        logic [4:0]  e_id;
        logic [31:0] e_dat;
    } vec_t;

    ent_t mq[$];
    int   m_starve = 0;
    int   tests = 0;
    int   fails = 0;

    logic        a_we, a_stall, a_rdy;
    logic [4:0]  a_id;
    logic [31:0] a_dat, a_pend;
    logic [2:0]  a_cnt;

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        for (int i = 0; i < mq.size(); i++) p[mq[i].id] = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the queue model, then advance the model at the edge.
    task automatic step(input logic rst, input logic wbe, input logic [4:0] wbid, input logic [31:0] wbd,
                        input logic av, input logic [4:0] aid, input logic [31:0] ad);
        logic ga;
        logic ewe;
        int   cnt;
        ent_t sel;
        @(negedge clock);
        reset = rst; wbWriteEnabled = wbe; wbWriteId = wbid; wbDataWrite = wbd;
        auxValid = av; auxWriteId = aid; auxDataWrite = ad;
        #1;
        a_we = regWriteEnabled; a_stall = wbStall; a_rdy = auxReady; a_id = regWriteId;
        a_dat = regDataWrite; a_pend = pendingMask; a_cnt = fifoCount;
        cnt = mq.size();
        ga = 1'b0;
        if (!rst) begin
            chk("rst_we", a_we, 0);
            chk("rst_stall", a_stall, 0);
            chk("rst_ready", a_rdy, 0);
            chk("rst_count", a_cnt, 0);
            chk("rst_pend", a_pend, 0);
        end else begin
            ga = (cnt > 0) && (!wbe || m_starve == LIMIT);
            if (ga) sel = mq[0];
            else    sel = {wbid, wbd};
            ewe = (ga || wbe) && (sel.id != 0);
            chk("we", a_we, ewe);
            chk("stall", a_stall, ga && wbe);
            chk("ready", a_rdy, cnt < DEPTH);
            chk("count", a_cnt, cnt);
            chk("pend", a_pend, model_pend());
            if (ewe) begin
                chk("wr_id", a_id, sel.id);
                chk("wr_dat", a_dat, sel.dat);
            end
        end
        @(posedge clock);
        if (!rst) begin
            mq.delete();
            m_starve = 0;
        end else begin
            if (ga) void'(mq.pop_front());
            if (av && cnt < DEPTH && aid != 0) mq.push_back({aid, ad});
            if (cnt == 0 || ga)  m_starve = 0;
            else if (wbe)        m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end
    endtask

    vec_t vecs[11];

    initial begin
        reset = 1'b0; wbWriteEnabled = 1'b0; wbWriteId = '0; wbDataWrite = '0;
        auxValid = 1'b0; auxWriteId = '0; auxDataWrite = '0;

        //           rst   wbe   wbid  wbd           av    aid   ad          we    stl   rdy   cnt   pend        id    dat
        vecs[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,     1'b0, 1'b0, 1'b0, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,     1'b0, 1'b0, 1'b0, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,     1'b0, 1'b0, 1'b0, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEAD,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 1'b1, 3'd1, 32'h20,     5'd5, 32'hDEAD};
        vecs[6]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hBEEF,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 3'd0, 32'h0,      5'd0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 1'b1, 3'd1 - 3'd1, 32'h0, 5'd3, 32'h33};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].wbe, vecs[i].wbid, vecs[i].wbd, vecs[i].av, vecs[i].aid, vecs[i].ad);
            chk("tbl_we", a_we, vecs[i].e_we);
            chk("tbl_stall", a_stall, vecs[i].e_stall);
            chk("tbl_ready", a_rdy, vecs[i].e_rdy);
            chk("tbl_count", a_cnt, vecs[i].e_cnt);
            chk("tbl_pend", a_pend, vecs[i].e_pend);
            if (vecs[i].e_we) begin
                chk("tbl_id", a_id, vecs[i].e_id);
                chk("tbl_dat", a_dat, vecs[i].e_dat);
            end
        end

        // Starvation: aux id 7 waits behind continuous write-back to id 3.
        step(1, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0);
            chk("starve_wait_id", a_id, 3);
            chk("starve_wait_stall", a_stall, 0);
        end
        step(1, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0);
        chk("starve_grant_stall", a_stall, 1);
        chk("starve_grant_id", a_id, 7);
        chk("starve_grant_dat", a_dat, 32'h77);
        step(1, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0);
        chk("starve_resume_stall", a_stall, 0);
        chk("starve_resume_id", a_id, 3);

        // Full FIFO, three fill/drain rounds so the pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(1, 1, 5'd3, 32'h33, 1, 5'(8 + 4*r + k), 32'hA000 + 32'(4*r + k));
            end
            step(1, 1, 5'd3, 32'h33, 1, 5'd20, 32'hF00D);
            chk("full_count", a_cnt, 4);
            chk("full_ready", a_rdy, 0);
            step(1, 0, 5'd0, 32'h0, 1, 5'd21, 32'hF11D);
            chk("full_pop_ready", a_rdy, 0);
            chk("drain_id0", a_id, 8 + 4*r);
            for (int k = 1; k < 4; k++) begin
                step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
                chk("drain_id", a_id, 8 + 4*r + k);
                chk("drain_dat", a_dat, 32'hA000 + 32'(4*r + k));
            end
            step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
            chk("drained_count", a_cnt, 0);
        end

        // Reset while entries are buffered throws them away.
        for (int k = 0; k < 3; k++) step(1, 1, 5'd3, 32'h33, 1, 5'(22 + k), 32'hB0 + 32'(k));
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
            chk("postrst_count", a_cnt, 0);
            chk("postrst_pend", a_pend, 0);
            chk("postrst_we", a_we, 0);
        end

        // Random traffic; write-back never targets a register still pending in the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] p;
            logic [4:0]  wid;
            p   = model_pend();
            wid = 5'($urandom_range(31));
            if (p[wid]) wid = 5'd0;
            step(($urandom_range(99) != 0), 1'($urandom_range(1)), wid, $urandom,
                 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
